// File: rtl/apb_mem_pkg.sv
// Shared types and default sizing for the APB scratch memory completer.
package apb_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_MEM_DEPTH   = 64;
    localparam int unsigned DEF_WAIT_CYCLES = 0;

    typedef logic [0:0] state_e;

    localparam state_e IDLE   = 1'b0;
    localparam state_e ACCESS = 1'b1;

endpackage

// File: rtl/apb_mem_array.sv
// Word array with synchronous write, asynchronous read and synchronous clear.
module apb_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned IDX_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_WIDTH-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a word-addressed RAM, with programmable wait states
// and PSLVERR on addresses beyond the implemented depth.
module apb_slave_mem
    import apb_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  _PCLK,
    input  logic                  _PRESETn,
    input  logic                  _PSEL1,
    input  logic                  _PWRITE,
    input  logic                  _PENABLE,
    input  logic [ADDR_WIDTH-1:0] _PADDR,
    input  logic [DATA_WIDTH-1:0] _PWDATA,
    output logic [DATA_WIDTH-1:0] _PRDATA,
    output logic                  _PREADY,
    output logic                  _PSLVERR
);

    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [31:0]           paddr_ext;
    logic                  in_range;
    logic                  setup;
    logic                  pready;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign paddr_ext = 32'(_PADDR);
    assign in_range  = paddr_ext < MEM_DEPTH;
    assign setup     = _PSEL1 && !_PENABLE;

    // Ready depends only on registered state so no input reaches PREADY combinationally.
    assign pready = (state_q == ACCESS) && (cnt_q == CntW'(WAIT_CYCLES));
    assign mem_we = (state_q == ACCESS) && _PSEL1 && _PENABLE && pready && write_q && !err_q;

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_WIDTH  (IdxW)
    ) u_array (
        .clk_i   (_PCLK),
        .rst_i   (_PRESETn),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (_PWDATA),
        .raddr_i (_PADDR[IdxW-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        if (setup) begin
            // Setup is accepted from either state so back-to-back transfers need no idle cycle.
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = _PADDR[IdxW-1:0];
            write_d = _PWRITE;
            err_d   = !in_range;
            if (!_PWRITE) begin
                prdata_d = in_range ? mem_rdata : '0;
            end
        end else if (state_q == ACCESS) begin
            if (!_PSEL1 || (_PENABLE && pready)) begin
                state_d = IDLE;
            end else if (_PENABLE) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge _PCLK) begin
        if (_PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
        end
    end

    assign _PRDATA  = prdata_q;
    assign _PREADY  = pready;
    assign _PSLVERR = pready && err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a zero-wait and a two-wait instance driven by directed
// and random APB transfers, checked against an array model of the memory.
module tb_apb_slave_mem;

    localparam int unsigned DEPTH = 64;

    logic        clk;
    logic        rst;
    logic [1:0]  psel;
    logic        pwrite;
    logic        penable;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2;
    logic        pslverr0, pslverr2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];

    apb_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
        ._PCLK    (clk),
        ._PRESETn (rst),
        ._PSEL1   (psel[0]),
        ._PWRITE  (pwrite),
        ._PENABLE (penable),
        ._PADDR   (paddr),
        ._PWDATA  (pwdata),
        ._PRDATA  (prdata0),
        ._PREADY  (pready0),
        ._PSLVERR (pslverr0)
    );

    apb_slave_mem #(.WAIT_CYCLES(2)) u_dut2 (
        ._PCLK    (clk),
        ._PRESETn (rst),
        ._PSEL1   (psel[1]),
        ._PWRITE  (pwrite),
        ._PENABLE (penable),
        ._PADDR   (paddr),
        ._PWDATA  (pwdata),
        ._PRDATA  (prdata2),
        ._PREADY  (pready2),
        ._PSLVERR (pslverr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready2;
    endfunction

    function automatic logic slverr(input int d);
        return (d == 0) ? pslverr0 : pslverr2;
    endfunction

    function automatic logic [31:0] rdata(input int d);
        return (d == 0) ? prdata0 : prdata2;
    endfunction

    function automatic int waits(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < int'(DEPTH); i++) mdl[d][i] = '0;
        end
    endtask

    // One complete transfer; returns at the negedge where PREADY is seen high.
    task automatic do_xfer(input int d, input bit wr, input int a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
        int          cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = (a >= int'(DEPTH));
        if (wr) exp_rd = last_rd[d];
        else    exp_rd = exp_err ? 32'h0 : mdl[d][a];
        @(negedge clk);
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a[7:0];
        pwdata  = wd;
        check_eq("setup_pready", {31'b0, rdy(d)}, 32'h0);
        @(negedge clk);
        penable = 1'b1;
        // Address and direction must be ignored once latched.
        paddr   = 8'($urandom);
        pwrite  = ~wr;
        cyc = 1;
        while (!rdy(d) && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        if (!rdy(d)) begin
            check_eq("pready_timeout", {31'b0, rdy(d)}, 32'h1);
        end
        check_eq("latency", cyc, waits(d) + 1);
        check_eq(wr ? "wr_prdata_hold" : "rd_data", rdata(d), exp_rd);
        check_eq("pslverr", {31'b0, slverr(d)}, {31'b0, exp_err});
        if (wr && !exp_err) mdl[d][a] = wd;
        if (!wr) last_rd[d] = exp_rd;
        rd  = rdata(d);
        err = slverr(d);
    endtask

    task automatic go_idle();
        @(negedge clk);
        psel    = '0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        rst = 1'b1; psel = '0; pwrite = 1'b0; penable = 1'b0; paddr = '0; pwdata = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check_eq("rst_prdata0", prdata0, 32'h0);
        check_eq("rst_pready0", {31'b0, pready0}, 32'h0);
        check_eq("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        check_eq("rst_pready2", {31'b0, pready2}, 32'h0);
        rst = 1'b0;

        do_xfer(0, 1'b0, 'h05, '0, rd, err);
        check_eq("t1_rd05", rd, 32'h0);
        go_idle();

        do_xfer(0, 1'b1, 'h10, 32'hDEADBEEF, rd, err);
        go_idle();
        do_xfer(0, 1'b0, 'h10, '0, rd, err);
        check_eq("t2_rd10", rd, 32'hDEADBEEF);
        go_idle();

        do_xfer(1, 1'b1, 'h3F, 32'hCAFEF00D, rd, err);
        go_idle();
        do_xfer(1, 1'b0, 'h3F, '0, rd, err);
        check_eq("t3_rd3f", rd, 32'hCAFEF00D);
        go_idle();

        do_xfer(0, 1'b1, 'h00, 32'h12345678, rd, err);
        do_xfer(0, 1'b1, 'h40, 32'hBADBAD00, rd, err);
        check_eq("t4_wr_err", {31'b0, err}, 32'h1);
        do_xfer(0, 1'b0, 'h00, '0, rd, err);
        check_eq("t4_rd00", rd, 32'h12345678);
        do_xfer(0, 1'b0, 'h40, '0, rd, err);
        check_eq("t4_rd_err_data", rd, 32'h0);
        go_idle();

        do_xfer(0, 1'b1, 'h01, 32'h11, rd, err);
        do_xfer(0, 1'b1, 'h02, 32'h22, rd, err);
        do_xfer(0, 1'b0, 'h01, '0, rd, err);
        check_eq("t5_rd01", rd, 32'h11);
        do_xfer(0, 1'b0, 'h02, '0, rd, err);
        check_eq("t5_rd02", rd, 32'h22);
        go_idle();

        // Abort: setup then drop PSEL1 in place of the access phase.
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            psel = '0; psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b1;
            paddr = 8'h03; pwdata = 32'h55;
            @(negedge clk);
            psel = '0;
            do_xfer(d, 1'b0, 'h03, '0, rd, err);
            check_eq("t6_abort_rd03", rd, 32'h0);
            go_idle();
        end

        // Reset in the middle of a waited write.
        do_xfer(1, 1'b0, 'h3F, '0, rd, err);
        go_idle();
        @(negedge clk);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 32'h55;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        psel = '0; penable = 1'b0;
        check_eq("t6_rst_prdata2", prdata2, 32'h0);
        check_eq("t6_rst_pready2", {31'b0, pready2}, 32'h0);
        check_eq("t6_rst_pslverr2", {31'b0, pslverr2}, 32'h0);
        rst = 1'b0;
        clear_model();
        do_xfer(1, 1'b0, 'h03, '0, rd, err);
        check_eq("t6_rst_rd03", rd, 32'h0);
        go_idle();

        for (int n = 0; n < 300; n++) begin
            do_xfer(int'($urandom_range(0, 1)), 1'($urandom), int'($urandom_range(0, 71)),
                    $urandom, rd, err);
            if ($urandom_range(0, 2) == 0) go_idle();
        end
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
